microwave_timer: RTL and testbench

//  Countdown cook timer that produces the `finish` input of the microwave control FSM.
//  It consumes that FSM's `heat` output and counts down the programmed mm:ss only while heating.
//  `finish` is asserted when the time is spent. The time value is BCD for direct 7-seg display.

---
 rtl/microwave_timer_if.sv | 19 +
 rtl/microwave_timer.sv | 143 ++++++++++++++
 tb/tb_microwave_timer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microwave_timer_if.sv
// Signal bundle between the microwave control FSM (master) and the cook timer (slave).
interface microwave_timer_if;
  logic       heat;
  logic       load;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       clear;
  logic       add30;
  logic       finish;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       running;
  logic       load_err;

  modport master (output heat, load, load_mm, load_ss, clear, add30,
                  input  finish, mm, ss, running, load_err);
  modport slave  (input  heat, load, load_mm, load_ss, clear, add30,
                  output finish, mm, ss, running, load_err);
endinterface

// File: rtl/microwave_timer.sv
// BCD mm:ss countdown cook timer; counts only while heat=1, holds finish in DONE.
// Optional +30 s strobe is built only when MW_TIMER_ADD30_EN is defined.
module microwave_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input logic              clk,
  input logic              nrst,
  microwave_timer_if.slave tif
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, ARMED, RUN, HOLD, DONE} state_t;

  state_t        state;
  logic [7:0]    mm_q, ss_q;
  logic [PW-1:0] presc;
  logic          finish_q, running_q, err_q;

  logic          ld_ok, ld_zero, tk, add30_act;
  logic [15:0]   t_time, n_time;

  function automatic logic [15:0] bcd_dec(input logic [7:0] m, input logic [7:0] s);
    logic [7:0] nm, ns;
    nm = m;
    ns = s;
    if (s != 8'h00) begin
      ns = (s[3:0] == 4'd0) ? {s[7:4] - 4'd1, 4'd9} : {s[7:4], s[3:0] - 4'd1};
    end else begin
      ns = 8'h59;
      nm = (m[3:0] == 4'd0) ? {m[7:4] - 4'd1, 4'd9} : {m[7:4], m[3:0] - 4'd1};
    end
    return {nm, ns};
  endfunction

`ifdef MW_TIMER_ADD30_EN
  // +30 s only touches the tens-of-seconds digit; a carry bumps minutes, saturating at 99:59.
  function automatic logic [15:0] bcd_add30(input logic [15:0] t);
    logic [7:0] m, s, nm, ns;
    m  = t[15:8];
    s  = t[7:0];
    nm = m;
    ns = {s[7:4] + 4'd3, s[3:0]};
    if (s[7:4] >= 4'd3) begin
      if (m == 8'h99) return 16'h9959;
      ns = {s[7:4] - 4'd3, s[3:0]};
      nm = (m[3:0] == 4'd9) ? {m[7:4] + 4'd1, 4'd0} : {m[7:4], m[3:0] + 4'd1};
    end
    return {nm, ns};
  endfunction

  assign add30_act = tif.add30;
`else
  logic unused_add30;
  assign unused_add30 = tif.add30;
  assign add30_act    = 1'b0;
`endif

  assign ld_ok   = (tif.load_mm[7:4] <= 4'd9) && (tif.load_mm[3:0] <= 4'd9) &&
                   (tif.load_ss[7:4] <= 4'd5) && (tif.load_ss[3:0] <= 4'd9);
  assign ld_zero = (tif.load_mm == 8'h00) && (tif.load_ss == 8'h00);
  assign tk      = (state == RUN) && tif.heat && (presc == PMAX);

  // Tick is applied before any same-cycle +30 s.
  always_comb begin
    t_time = tk ? bcd_dec(mm_q, ss_q) : {mm_q, ss_q};
`ifdef MW_TIMER_ADD30_EN
    n_time = add30_act ? bcd_add30(t_time) : t_time;
`else
    n_time = t_time;
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      mm_q      <= 8'h00;
      ss_q      <= 8'h00;
      presc     <= '0;
      finish_q  <= 1'b0;
      running_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (tif.clear) begin
        state     <= IDLE;
        mm_q      <= 8'h00;
        ss_q      <= 8'h00;
        presc     <= '0;
        finish_q  <= 1'b0;
        running_q <= 1'b0;
      end else if (tif.load && ld_ok) begin
        state     <= ld_zero ? IDLE : ARMED;
        mm_q      <= tif.load_mm;
        ss_q      <= tif.load_ss;
        presc     <= '0;
        finish_q  <= 1'b0;
        running_q <= 1'b0;
      end else begin
        if (tif.load) err_q <= 1'b1;
        case (state)
          IDLE, DONE: begin
            if (add30_act) begin
              state     <= ARMED;
              mm_q      <= 8'h00;
              ss_q      <= 8'h30;
              presc     <= '0;
              finish_q  <= 1'b0;
              running_q <= 1'b0;
            end
          end
          ARMED, HOLD: begin
            if (add30_act) begin
              {mm_q, ss_q} <= n_time;
            end else if (tif.heat) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (tif.heat) presc <= tk ? '0 : presc + 1'b1;
            {mm_q, ss_q} <= n_time;
            if (n_time == 16'h0000) begin
              state     <= DONE;
              finish_q  <= 1'b1;
              running_q <= 1'b0;
            end else if (!tif.heat && !add30_act) begin
              state     <= HOLD;
              running_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign tif.finish   = finish_q;
  assign tif.running  = running_q;
  assign tif.load_err = err_q;
  assign tif.mm       = mm_q;
  assign tif.ss       = ss_q;
endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICK_DIV=4; expected values hand-computed.
module tb_microwave_timer;
  logic clk, nrst;
  int   n_chk, n_fail;

  microwave_timer_if tif ();
  microwave_timer #(.TICK_DIV(4)) dut (.clk(clk), .nrst(nrst), .tif(tif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    tif.load = 1'b1; tif.load_mm = m; tif.load_ss = s;
    step(1);
    tif.load = 1'b0;
  endtask

  task automatic do_clear();
    tif.clear = 1'b1;
    step(1);
    tif.clear = 1'b0;
  endtask

  task automatic do_add30();
    tif.add30 = 1'b1;
    step(1);
    tif.add30 = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    step(2);
    n_chk++;
    if ({tif.finish, tif.running, tif.load_err, tif.mm, tif.ss} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_state: got fin=%b run=%b err=%b %h:%h, want 0 0 0 00:00",
               tif.finish, tif.running, tif.load_err, tif.mm, tif.ss);
    end
    nrst = 1'b1;
    step(1);
  endtask

  task automatic test_basic_count();
    do_load(8'h00, 8'h02);
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0002 || tif.running !== 1'b0) begin
      n_fail++; $display("FAIL load_0002: got %h:%h run=%b, want 00:02 run=0", tif.mm, tif.ss, tif.running);
    end
    tif.heat = 1'b1;
    step(1);
    n_chk++;
    if (tif.running !== 1'b1) begin
      n_fail++; $display("FAIL run_enter: got running=%b, want 1", tif.running);
    end
    step(3);
    n_chk++;
    if (tif.ss !== 8'h02) begin
      n_fail++; $display("FAIL pre_tick: got ss=%h, want 02", tif.ss);
    end
    step(1);
    n_chk++;
    if (tif.ss !== 8'h01) begin
      n_fail++; $display("FAIL first_tick: got ss=%h, want 01", tif.ss);
    end
    step(3);
    n_chk++;
    if (tif.ss !== 8'h01 || tif.finish !== 1'b0) begin
      n_fail++; $display("FAIL pre_done: got ss=%h fin=%b, want 01 0", tif.ss, tif.finish);
    end
    step(1);
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0000 || tif.finish !== 1'b1 || tif.running !== 1'b0) begin
      n_fail++; $display("FAIL done: got %h:%h fin=%b run=%b, want 00:00 1 0",
                         tif.mm, tif.ss, tif.finish, tif.running);
    end
  endtask

  task automatic test_hold_resume();
    tif.heat = 1'b0;
    do_clear();
    do_load(8'h01, 8'h00);
    tif.heat = 1'b1;
    step(5);
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0059) begin
      n_fail++; $display("FAIL borrow_min: got %h:%h, want 00:59", tif.mm, tif.ss);
    end
    step(2);
    tif.heat = 1'b0;
    step(1);
    n_chk++;
    if (tif.running !== 1'b0) begin
      n_fail++; $display("FAIL hold_enter: got running=%b, want 0", tif.running);
    end
    step(10);
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0059) begin
      n_fail++; $display("FAIL hold_frozen: got %h:%h, want 00:59", tif.mm, tif.ss);
    end
    tif.heat = 1'b1;
    step(2);
    n_chk++;
    if (tif.ss !== 8'h59 || tif.running !== 1'b1) begin
      n_fail++; $display("FAIL resume_pre: got ss=%h run=%b, want 59 1", tif.ss, tif.running);
    end
    step(1);
    n_chk++;
    if (tif.ss !== 8'h58) begin
      n_fail++; $display("FAIL resume_tick: got ss=%h, want 58", tif.ss);
    end
  endtask

  task automatic test_load_err();
    tif.heat = 1'b0;
    step(1);
    do_load(8'h00, 8'h5A);
    n_chk++;
    if (tif.load_err !== 1'b1 || {tif.mm, tif.ss} !== 16'h0058 || tif.running !== 1'b0) begin
      n_fail++; $display("FAIL err_ss: got err=%b %h:%h run=%b, want 1 00:58 0",
                         tif.load_err, tif.mm, tif.ss, tif.running);
    end
    step(1);
    n_chk++;
    if (tif.load_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse: got err=%b, want 0", tif.load_err);
    end
    do_load(8'hA0, 8'h10);
    n_chk++;
    if (tif.load_err !== 1'b1 || {tif.mm, tif.ss} !== 16'h0058) begin
      n_fail++; $display("FAIL err_mm: got err=%b %h:%h, want 1 00:58", tif.load_err, tif.mm, tif.ss);
    end
    do_load(8'h00, 8'h00);
    tif.heat = 1'b1;
    step(3);
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0000 || tif.finish !== 1'b0 || tif.running !== 1'b0) begin
      n_fail++; $display("FAIL load_zero_idle: got %h:%h fin=%b run=%b, want 00:00 0 0",
                         tif.mm, tif.ss, tif.finish, tif.running);
    end
    tif.heat = 1'b0;
  endtask

  task automatic test_done_hold();
    do_load(8'h00, 8'h01);
    tif.heat = 1'b1;
    step(5);
    n_chk++;
    if (tif.finish !== 1'b1) begin
      n_fail++; $display("FAIL done_reach: got finish=%b, want 1", tif.finish);
    end
    tif.heat = 1'b0;
    step(3);
    tif.heat = 1'b1;
    step(2);
    n_chk++;
    if (tif.finish !== 1'b1 || {tif.mm, tif.ss} !== 16'h0000 || tif.running !== 1'b0) begin
      n_fail++; $display("FAIL done_sticky: got fin=%b %h:%h run=%b, want 1 00:00 0",
                         tif.finish, tif.mm, tif.ss, tif.running);
    end
    tif.heat = 1'b0;
    do_clear();
    n_chk++;
    if (tif.finish !== 1'b0 || {tif.mm, tif.ss} !== 16'h0000) begin
      n_fail++; $display("FAIL done_clear: got fin=%b %h:%h, want 0 00:00", tif.finish, tif.mm, tif.ss);
    end
  endtask

  task automatic test_priority_reload();
    do_load(8'h00, 8'h05);
    tif.clear = 1'b1; tif.load = 1'b1; tif.add30 = 1'b1;
    tif.load_mm = 8'h12; tif.load_ss = 8'h34;
    step(1);
    tif.clear = 1'b0; tif.load = 1'b0; tif.add30 = 1'b0;
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0000 || tif.running !== 1'b0 || tif.finish !== 1'b0) begin
      n_fail++; $display("FAIL clear_prio: got %h:%h run=%b fin=%b, want 00:00 0 0",
                         tif.mm, tif.ss, tif.running, tif.finish);
    end
    do_load(8'h00, 8'h02);
    tif.heat = 1'b1;
    step(5);
    step(2);
    do_load(8'h00, 8'h03);
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0003 || tif.running !== 1'b0) begin
      n_fail++; $display("FAIL reload_run: got %h:%h run=%b, want 00:03 0", tif.mm, tif.ss, tif.running);
    end
    step(4);
    n_chk++;
    if (tif.ss !== 8'h03 || tif.running !== 1'b1) begin
      n_fail++; $display("FAIL presc_restart: got ss=%h run=%b, want 03 1", tif.ss, tif.running);
    end
    step(1);
    n_chk++;
    if (tif.ss !== 8'h02) begin
      n_fail++; $display("FAIL reload_tick: got ss=%h, want 02", tif.ss);
    end
    tif.heat = 1'b0;
    step(1);
  endtask

  task automatic test_add30();
    do_clear();
    do_add30();
`ifdef MW_TIMER_ADD30_EN
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0030 || tif.running !== 1'b0) begin
      n_fail++; $display("FAIL add30_idle: got %h:%h run=%b, want 00:30 0", tif.mm, tif.ss, tif.running);
    end
    tif.heat = 1'b1;
    step(1);
    n_chk++;
    if (tif.running !== 1'b1) begin
      n_fail++; $display("FAIL add30_armed: got running=%b, want 1", tif.running);
    end
    tif.heat = 1'b0;
    do_load(8'h00, 8'h45);
    do_add30();
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0115) begin
      n_fail++; $display("FAIL add30_carry: got %h:%h, want 01:15", tif.mm, tif.ss);
    end
    do_load(8'h99, 8'h50);
    do_add30();
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h9959) begin
      n_fail++; $display("FAIL add30_sat: got %h:%h, want 99:59", tif.mm, tif.ss);
    end
    do_load(8'h00, 8'h10);
    tif.heat = 1'b1;
    step(4);
    do_add30();
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0039 || tif.running !== 1'b1) begin
      n_fail++; $display("FAIL add30_tick: got %h:%h run=%b, want 00:39 1", tif.mm, tif.ss, tif.running);
    end
    tif.heat = 1'b0;
    step(1);
`else
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0000 || tif.running !== 1'b0) begin
      n_fail++; $display("FAIL add30_off_idle: got %h:%h run=%b, want 00:00 0", tif.mm, tif.ss, tif.running);
    end
    do_load(8'h00, 8'h10);
    do_add30();
    n_chk++;
    if ({tif.mm, tif.ss} !== 16'h0010) begin
      n_fail++; $display("FAIL add30_off_armed: got %h:%h, want 00:10", tif.mm, tif.ss);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_load(8'h00, 8'h01);
    tif.heat = 1'b1;
    step(2);
    nrst = 1'b0;
    #1;
    n_chk++;
    if ({tif.finish, tif.running, tif.mm, tif.ss} !== 18'h0) begin
      n_fail++; $display("FAIL reset_mid: got fin=%b run=%b %h:%h, want 0 0 00:00",
                         tif.finish, tif.running, tif.mm, tif.ss);
    end
    step(6);
    n_chk++;
    if (tif.finish !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_fin: got finish=%b, want 0", tif.finish);
    end
    tif.heat = 1'b0;
    nrst = 1'b1;
    step(1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    nrst = 1'b0;
    tif.heat = 1'b0; tif.load = 1'b0; tif.clear = 1'b0; tif.add30 = 1'b0;
    tif.load_mm = 8'h00; tif.load_ss = 8'h00;
    test_reset();
    test_basic_count();
    test_hold_resume();
    test_load_err();
    test_done_hold();
    test_priority_reload();
    test_add30();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
